// File: rtl/mc_core_pkg.sv
// Shared types and constants for the mc_core multi-cycle RV32 subset core.
package mc_core_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluSlt,
    AluXor,
    AluOr,
    AluAnd
  } alu_op_e;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  // True when opcode/funct3/funct7 name one of the supported instructions.
  function automatic logic is_legal(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
    logic alu_f3;
    alu_f3 = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
             (f3 == 3'b110) || (f3 == 3'b111);
    case (opc)
      OpcLui, OpcAuipc, OpcJal: return 1'b1;
      OpcBranch:                return (f3 == 3'b000) || (f3 == 3'b001);
      OpcLoad, OpcStore:        return f3 == 3'b010;
      OpcOpImm:                 return alu_f3;
      OpcOp:                    return ((f7 == 7'b0000000) && alu_f3) ||
                                       ((f7 == 7'b0100000) && (f3 == 3'b000));
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: add/sub/signed-compare/logic ops, wrapping modulo 2^XLEN.
module mc_alu import mc_core_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  alu_op_e         i_op,
  output logic [XLEN-1:0] o_res
);

  logic w_lt;
  assign w_lt = $signed(i_a) < $signed(i_b);

  // Select the result of the requested operation.
  always_comb begin
    o_res = i_a + i_b;
    case (i_op)
      AluAdd:  o_res = i_a + i_b;
      AluSub:  o_res = i_a - i_b;
      AluSlt:  o_res = {{(XLEN-1){1'b0}}, w_lt};
      AluXor:  o_res = i_a ^ i_b;
      AluOr:   o_res = i_a | i_b;
      AluAnd:  o_res = i_a & i_b;
      default: o_res = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle RV32 subset core: FETCH/DECODE/EXEC/MEM/WB with a single memory port.
module mc_core import mc_core_pkg::*; #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     REG_ADDR_W = 5,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            retire,
  output logic            halted,
  output logic [XLEN-1:0] pc_out
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

  state_e r_state, w_state_next;

  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_aluout, r_mdr;
  logic [XLEN-1:0] r_rf [NumRegs];

  // Instruction fields; register indices are truncated to the file size.
  logic [6:0]            w_opc, w_f7;
  logic [2:0]            w_f3;
  logic [REG_ADDR_W-1:0] w_rd, w_rs1, w_rs2;
  assign w_opc = r_ir[6:0];
  assign w_f3  = r_ir[14:12];
  assign w_f7  = r_ir[31:25];
  assign w_rd  = r_ir[7 +: REG_ADDR_W];
  assign w_rs1 = r_ir[15 +: REG_ADDR_W];
  assign w_rs2 = r_ir[20 +: REG_ADDR_W];

  logic w_is_load, w_is_store, w_is_mem, w_is_branch, w_is_jal;
  logic w_is_lui, w_is_auipc, w_is_op, w_is_opimm, w_legal;
  assign w_is_load   = w_opc == OpcLoad;
  assign w_is_store  = w_opc == OpcStore;
  assign w_is_mem    = w_is_load || w_is_store;
  assign w_is_branch = w_opc == OpcBranch;
  assign w_is_jal    = w_opc == OpcJal;
  assign w_is_lui    = w_opc == OpcLui;
  assign w_is_auipc  = w_opc == OpcAuipc;
  assign w_is_op     = w_opc == OpcOp;
  assign w_is_opimm  = w_opc == OpcOpImm;
  assign w_legal     = is_legal(w_opc, w_f3, w_f7);

  // Sign-extended immediates.
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  assign w_imm_i = XLEN'($signed(r_ir[31:20]));
  assign w_imm_s = XLEN'($signed({r_ir[31:25], r_ir[11:7]}));
  assign w_imm_b = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));

  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_pc_plus4;
  assign w_rs1_val  = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
  assign w_rs2_val  = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
  assign w_pc_plus4 = r_pc + XLEN'(4);

  logic            w_taken;
  assign w_taken = w_f3[0] ? (r_a != r_b) : (r_a == r_b);

  logic [XLEN-1:0] w_alu_a, w_alu_b, w_alu_res;
  alu_op_e         w_alu_op;

  // ALU operand and operation selection for the EXEC cycle.
  always_comb begin
    w_alu_a  = r_a;
    w_alu_b  = w_imm_i;
    w_alu_op = AluAdd;
    if (w_is_lui)   w_alu_a = '0;
    if (w_is_auipc) w_alu_a = r_pc;
    if (w_is_op)                 w_alu_b = r_b;
    else if (w_is_store)         w_alu_b = w_imm_s;
    else if (w_is_lui || w_is_auipc) w_alu_b = w_imm_u;
    if (w_is_op || w_is_opimm) begin
      case (w_f3)
        3'b000:  w_alu_op = (w_is_op && w_f7[5]) ? AluSub : AluAdd;
        3'b010:  w_alu_op = AluSlt;
        3'b100:  w_alu_op = AluXor;
        3'b110:  w_alu_op = AluOr;
        3'b111:  w_alu_op = AluAnd;
        default: w_alu_op = AluAdd;
      endcase
    end
  end

  mc_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .i_a  (w_alu_a),
    .i_b  (w_alu_b),
    .i_op (w_alu_op),
    .o_res(w_alu_res)
  );

  logic w_misaligned;
  assign w_misaligned = w_alu_res[1:0] != 2'b00;

  // Next-state and memory/retire outputs; requests are suppressed while in reset.
  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = r_pc;
    mem_wdata    = r_b;
    retire       = 1'b0;
    case (r_state)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) w_state_next = StDecode;
      end
      StDecode: w_state_next = w_legal ? StExec : StTrap;
      StExec: begin
        if (w_is_mem) begin
          w_state_next = w_misaligned ? StTrap : StMem;
        end else if (w_is_branch) begin
          w_state_next = StFetch;
          retire       = 1'b1;
        end else begin
          w_state_next = StWb;
        end
      end
      StMem: begin
        mem_req  = 1'b1;
        mem_addr = r_aluout;
        mem_we   = w_is_store;
        if (mem_ready) begin
          w_state_next = w_is_store ? StFetch : StWb;
          retire       = w_is_store;
        end
      end
      StWb: begin
        w_state_next = StFetch;
        retire       = 1'b1;
      end
      StTrap:  w_state_next = StTrap;
      default: w_state_next = StTrap;
    endcase
    if (!rst) begin
      mem_req = 1'b0;
      retire  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= StFetch;
    else      r_state <= w_state_next;
  end

  // Datapath registers and register file, updated per FSM phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      for (int i = 0; i < NumRegs; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        StFetch: if (mem_ready) r_ir <= mem_rdata[31:0];
        StDecode: begin
          r_a      <= w_rs1_val;
          r_b      <= w_rs2_val;
          r_aluout <= r_pc + (w_is_jal ? w_imm_j : w_imm_b);
        end
        StExec: begin
          if (w_is_branch) begin
            r_pc <= w_taken ? r_aluout : w_pc_plus4;
          end else if (w_is_jal) begin
            r_pc     <= r_aluout;
            r_aluout <= w_pc_plus4;
          end else begin
            r_aluout <= w_alu_res;
            // A misaligned access traps with PC left on the faulting instruction.
            if (!(w_is_mem && w_misaligned)) r_pc <= w_pc_plus4;
          end
        end
        StMem: if (mem_ready && w_is_load) r_mdr <= mem_rdata;
        StWb:  if (w_rd != '0) r_rf[w_rd] <= w_is_load ? r_mdr : r_aluout;
        default: ;
      endcase
    end
  end

  assign halted = r_state == StTrap;
  assign pc_out = r_pc;

endmodule

// File: tb/tb_mc_core.sv
// Directed self-checking bench for mc_core with a behavioural word memory.
module tb_mc_core;
  import mc_core_pkg::*;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic [31:0] mem [128];
  int          stall_left;
  logic        hold_writes;

  int cyc, req_cnt, n_checks, n_errors;
  int ret_q[$];

  logic        pend_fire, pend_we, pend_stall;
  logic [31:0] pend_addr, pend_wdata;
  logic        prev_wait, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  logic [31:0] exp_g [16];

  assign mem_rdata = mem[mem_addr[8:2]];
  assign mem_ready = (stall_left == 0) && !(hold_writes && mem_we);

  mc_core #(
    .XLEN      (32),
    .REG_ADDR_W(4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .retire   (retire),
    .halted   (halted),
    .pc_out   (pc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OpcOp};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OpcStore};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OpcBranch};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
  endfunction

  // Observe one cycle at the falling edge and record what completes at the next rise.
  task automatic sample();
    @(negedge clk);
    cyc++;
    if (retire) ret_q.push_back(cyc);
    if (mem_req) req_cnt++;
    if (prev_wait && mem_req) begin
      chk("hold_addr", mem_addr, prev_addr);
      chk("hold_we", 32'(mem_we), 32'(prev_we));
      chk("hold_wdata", mem_wdata, prev_wdata);
    end
    prev_wait  = mem_req && !mem_ready;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
    pend_fire  = mem_req && mem_ready;
    pend_we    = mem_we;
    pend_addr  = mem_addr;
    pend_wdata = mem_wdata;
    pend_stall = mem_req && (stall_left > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pend_fire && pend_we) mem[pend_addr[8:2]] = pend_wdata;
    if (pend_stall) stall_left--;
    sample();
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    hold_writes = 1'b0;
    stall_left  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", pc_out, 0);
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
  endtask

  task automatic start();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    cyc        = 0;
    req_cnt    = 0;
    ret_q.delete();
    prev_wait  = 1'b0;
    pend_fire  = 1'b0;
    pend_stall = 1'b0;
    sample();
  endtask

  task automatic run_until_halt(input int bound);
    int n;
    n = 0;
    while (!halted && n < bound) begin
      tick();
      n++;
    end
    chk("halt_reached", 32'(halted), 1);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b0;
    hold_writes = 1'b0;
    stall_left  = 0;
    cyc         = 0;
    req_cnt     = 0;
    prev_wait   = 1'b0;
    pend_fire   = 1'b0;
    pend_stall  = 1'b0;
    exp_g = '{32'h0, 32'h12345000, 32'h678, 32'h12345678, 32'hFFFFFFFE, 32'h1, 32'h67A,
              32'hEDCBA986, 32'h70, 32'hFFFFF987, 32'h1024, 32'h2C, 32'h1, 32'h0,
              32'h123450AB, 32'hFFFFFFFF};

    // ADDI x1,x0,5 ; ADD x2,x1,x1 ; SW x2,64(x0) ; illegal
    do_reset();
    mem[0] = enc_i(5, 0, 3'b000, 1, OpcOpImm);
    mem[1] = enc_r(7'h00, 1, 1, 3'b000, 2);
    mem[2] = enc_s(64, 2, 0);
    start();
    chk("first_req", 32'(mem_req), 1);
    chk("first_addr", mem_addr, 0);
    repeat (7) tick();
    chk("add_pc", pc_out, 8);
    chk("add_ret_n", ret_q.size(), 2);
    chk("addi_ret_cyc", ret_q[0], 4);
    chk("add_ret_cyc", ret_q[1], 8);
    run_until_halt(50);
    chk("add_x2", mem[16], 10);
    chk("sw_ret_cyc", ret_q[2], 12);
    chk("illegal_pc", pc_out, 12);

    // BNE x0,x0,+8 (not taken) ; BEQ x0,x0,-4 (taken)
    do_reset();
    mem[0] = enc_b(8, 0, 0, 3'b001);
    mem[1] = enc_b(-4, 0, 0, 3'b000);
    start();
    repeat (3) tick();
    chk("bne_pc", pc_out, 4);
    repeat (3) tick();
    chk("beq_pc", pc_out, 0);
    chk("bne_ret_cyc", ret_q[0], 3);
    chk("beq_ret_cyc", ret_q[1], 6);
    chk("br_halted", 32'(halted), 0);

    // LW x5,0x40(x0) with 3 fetch wait states ; SW x5,0x44(x0)
    do_reset();
    mem[0]  = enc_i(32'h40, 0, 3'b010, 5, OpcLoad);
    mem[1]  = enc_s(32'h44, 5, 0);
    mem[16] = 32'hDEADBEEF;
    stall_left = 3;
    start();
    repeat (7) tick();
    chk("lw_ret_n", ret_q.size(), 1);
    chk("lw_ret_cyc", ret_q[0], 8);
    run_until_halt(50);
    chk("lw_data", mem[17], 32'hDEADBEEF);
    chk("lw_trap_pc", pc_out, 8);

    // LW x3,1(x0): misaligned, traps without a data request
    do_reset();
    mem[0] = enc_i(1, 0, 3'b010, 3, OpcLoad);
    start();
    repeat (5) tick();
    chk("mis_halted", 32'(halted), 1);
    chk("mis_pc", pc_out, 0);
    chk("mis_req_cnt", req_cnt, 1);
    chk("mis_req_now", 32'(mem_req), 0);
    chk("mis_retire_n", ret_q.size(), 0);

    // Opcode 0x7F traps out of DECODE
    do_reset();
    mem[0] = 32'h0000007F;
    start();
    tick();
    chk("op7f_dec", 32'(halted), 0);
    tick();
    chk("op7f_trap", 32'(halted), 1);
    chk("op7f_pc", pc_out, 0);

    // Reset during a stalled SW: request drops, memory and PC untouched
    do_reset();
    mem[0]  = enc_i(32'h55, 0, 3'b000, 1, OpcOpImm);
    mem[1]  = enc_s(64, 1, 0);
    mem[16] = 32'h1234;
    hold_writes = 1'b1;
    start();
    begin
      int n;
      n = 0;
      while (!(mem_req && mem_we) && n < 20) begin
        tick();
        n++;
      end
    end
    chk("sw_req_cyc", cyc, 8);
    tick();
    chk("sw_waiting", 32'(mem_req), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    hold_writes = 1'b0;
    chk("rstmid_req", 32'(mem_req), 0);
    chk("rstmid_pc", pc_out, 0);
    chk("rstmid_halted", 32'(halted), 0);
    chk("rstmid_mem", mem[16], 32'h1234);

    // ALU/LUI/AUIPC/JAL mix, then dump x0..x15 to 0x100
    do_reset();
    mem[0]  = enc_u(20'h12345, 1, OpcLui);
    mem[1]  = enc_i(32'h678, 0, 3'b000, 2, OpcOpImm);
    mem[2]  = enc_r(7'h00, 2, 1, 3'b110, 3);
    mem[3]  = enc_i(-2, 0, 3'b000, 4, OpcOpImm);
    mem[4]  = enc_r(7'h00, 2, 4, 3'b010, 5);
    mem[5]  = enc_r(7'h20, 4, 2, 3'b000, 6);
    mem[6]  = enc_r(7'h00, 4, 3, 3'b100, 7);
    mem[7]  = enc_i(32'h0F0, 3, 3'b111, 8, OpcOpImm);
    mem[8]  = enc_i(-1, 2, 3'b100, 9, OpcOpImm);
    mem[9]  = enc_u(20'h00001, 10, OpcAuipc);
    mem[10] = enc_j(8, 11);
    mem[12] = enc_i(-1, 0, 3'b000, 15, OpcOpImm);
    mem[13] = enc_i(7, 0, 3'b000, 0, OpcOpImm);
    mem[14] = enc_i(0, 15, 3'b010, 12, OpcOpImm);
    mem[15] = enc_r(7'h00, 4, 2, 3'b010, 13);
    mem[16] = enc_i(32'h0AB, 1, 3'b110, 14, OpcOpImm);
    for (int k = 0; k < 16; k++) mem[17 + k] = enc_s(32'h100 + 4 * k, 5'(k), 0);
    start();
    run_until_halt(400);
    for (int k = 0; k < 16; k++) chk($sformatf("alu_x%0d", k), mem[64 + k], exp_g[k]);
    chk("alu_trap_pc", pc_out, 32'h84);
    chk("alu_ret_n", ret_q.size(), 32);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
